delta_sequencer: RTL and testbench

- Computes the output-layer error term delta[k] = (teach[k] - out[k]) * out[k] * (1 - out[k]) for N_OUT neurons.
- Uses one shared pipelined fp_add_sub core and one shared pipelined fp_multiplier core, both instantiated outside this block.
- Reads teach/output pairs from a synchronous RAM and writes deltas to an error RAM.
- A single start pulse from the training controller processes all neurons; a done pulse is returned.

---
 rtl/delta_sequencer.sv | 163 ++++++++++++++++
 tb/tb_delta_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delta_sequencer.sv
// rtl/delta_sequencer.sv - output-layer delta sequencer over shared fp add/sub and multiplier cores
module delta_sequencer #(
    parameter int N_OUT   = 4,
    parameter int ADDR_W  = 2,
    parameter int ADD_LAT = 7,
    parameter int MUL_LAT = 5
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iSTART,
    output logic              oBUSY,
    output logic              oDONE,
    output logic [ADDR_W-1:0] oRD_ADDR,
    input  logic [31:0]       iTEACH,
    input  logic [31:0]       iOUTPUT,
    output logic              oWR_EN,
    output logic [ADDR_W-1:0] oWR_ADDR,
    output logic [31:0]       oERROR,
    output logic              oADD_SUB,
    output logic [31:0]       oADD_A,
    output logic [31:0]       oADD_B,
    input  logic [31:0]       iADD_RESULT,
    output logic [31:0]       oMUL_A,
    output logic [31:0]       oMUL_B,
    input  logic [31:0]       iMUL_RESULT
);

    // Counter value is measured from the ISSUE_T cycle (count 0).
    localparam int CNT_LAST = ADD_LAT + 1 + 2 * MUL_LAT;
    localparam int CNT_W    = $clog2(CNT_LAST + 1);

    localparam logic [CNT_W-1:0]  C_DIFF   = CNT_W'(ADD_LAT);
    localparam logic [CNT_W-1:0]  C_MUL1   = CNT_W'(ADD_LAT + 1);
    localparam logic [CNT_W-1:0]  C_MUL2   = CNT_W'(ADD_LAT + 1 + MUL_LAT);
    localparam logic [CNT_W-1:0]  C_LAST   = CNT_W'(CNT_LAST);
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(N_OUT - 1);
    localparam logic [31:0]       FP_ONE   = 32'h3f80_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_ISSUE_T,
        S_ISSUE_1,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       oreg_q, oreg_d;
    logic [31:0]       diff_q, diff_d;
    logic [31:0]       err_q, err_d;
    logic              calc;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            wr_addr_q <= '0;
            cnt_q     <= '0;
            oreg_q    <= '0;
            diff_q    <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            wr_addr_q <= wr_addr_d;
            cnt_q     <= cnt_d;
            oreg_q    <= oreg_d;
            diff_q    <= diff_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        wr_addr_d = wr_addr_q;
        cnt_d     = cnt_q;
        oreg_d    = oreg_q;
        diff_d    = diff_q;
        err_d     = err_q;
        oWR_EN    = 1'b0;
        oDONE     = 1'b0;
        oADD_A    = '0;
        oADD_B    = '0;
        oMUL_A    = '0;
        oMUL_B    = '0;

        calc = (state_q == S_ISSUE_T) || (state_q == S_ISSUE_1) || (state_q == S_WAIT);

        // Core results are picked up purely by counter position, never by value.
        if (calc) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == C_DIFF) begin
                diff_d = iADD_RESULT;
            end
            if (cnt_q == C_MUL1) begin
                oMUL_A = oreg_q;
                oMUL_B = iADD_RESULT;
            end
            if (cnt_q == C_MUL2) begin
                oMUL_A = iMUL_RESULT;
                oMUL_B = diff_q;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (iSTART) begin
                    idx_d   = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                cnt_d   = '0;
                state_d = S_ISSUE_T;
            end
            S_ISSUE_T: begin
                oADD_A  = iTEACH;
                oADD_B  = iOUTPUT;
                oreg_d  = iOUTPUT;
                state_d = S_ISSUE_1;
            end
            S_ISSUE_1: begin
                oADD_A  = FP_ONE;
                oADD_B  = oreg_q;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == C_LAST) begin
                    err_d     = iMUL_RESULT;
                    wr_addr_d = idx_q;
                    state_d   = S_WRITE;
                end
            end
            S_WRITE: begin
                oWR_EN = 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + ADDR_W'(1);
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                oDONE   = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign oBUSY    = (state_q != S_IDLE) && (state_q != S_DONE);
    assign oRD_ADDR = idx_q;
    assign oWR_ADDR = wr_addr_q;
    assign oERROR   = err_q;
    assign oADD_SUB = 1'b0;

endmodule

// File: tb/tb_delta_sequencer.sv
// tb/tb_delta_sequencer.sv - scoreboard bench for delta_sequencer with behavioural fp cores
module tb_delta_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start   [3];
    logic        busy    [3];
    logic        done    [3];
    logic [1:0]  rd_addr [3];
    logic [31:0] teach   [3];
    logic [31:0] outv    [3];
    logic        wr_en   [3];
    logic [1:0]  wr_addr [3];
    logic [31:0] err     [3];
    logic        add_sub [3];
    logic [31:0] add_a   [3];
    logic [31:0] add_b   [3];
    logic [31:0] add_r   [3];
    logic [31:0] mul_a   [3];
    logic [31:0] mul_b   [3];
    logic [31:0] mul_r   [3];

    logic [31:0] tmem [3][4];
    logic [31:0] omem [3][4];
    logic [31:0] emem [3][4];
    logic [31:0] ap   [3][8];
    logic [31:0] mp   [3][8];

    typedef struct {
        int          inst;
        logic [1:0]  addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;
    wr_t wq[$];

    int cyc = 0;
    int n_vec = 0;
    int n_err = 0;
    int bs[3] = '{-1, -1, -1};
    int be[3] = '{-1, -1, -1};
    int dexp[3] = '{-1, -1, -1};
    int done_cnt[3] = '{0, 0, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int addl(input int i);
        return (i == 2) ? 3 : 7;
    endfunction
    function automatic int mull(input int i);
        return (i == 2) ? 2 : 5;
    endfunction
    function automatic int nout(input int i);
        return (i == 1) ? 1 : 4;
    endfunction
    function automatic int stride(input int i);
        return 4 + addl(i) + 2 * mull(i);
    endfunction

    function automatic real sp2r(input logic [31:0] b);
        int  e;
        real r;
        e = int'(b[30:23]);
        if (e == 0) return 0.0;
        r = 1.0 + real'(b[22:0]) / 8388608.0;
        if (e > 127) repeat (e - 127) r = r * 2.0;
        else repeat (127 - e) r = r / 2.0;
        return b[31] ? -r : r;
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        real         a;
        int          e;
        int          f;
        logic [31:0] w;
        if (r == 0.0) return 32'h0;
        a = (r < 0.0) ? -r : r;
        e = 127;
        while (a >= 2.0) begin a = a / 2.0; e++; end
        while (a < 1.0) begin a = a * 2.0; e--; end
        f = $rtoi((a - 1.0) * 8388608.0);
        w = {(r < 0.0), e[7:0], f[22:0]};
        return w;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    delta_sequencer #(.N_OUT(4), .ADDR_W(2), .ADD_LAT(7), .MUL_LAT(5)) u_a (
        .iCLK(clk), .iRST_N(rst_n), .iSTART(start[0]), .oBUSY(busy[0]), .oDONE(done[0]),
        .oRD_ADDR(rd_addr[0]), .iTEACH(teach[0]), .iOUTPUT(outv[0]), .oWR_EN(wr_en[0]),
        .oWR_ADDR(wr_addr[0]), .oERROR(err[0]), .oADD_SUB(add_sub[0]), .oADD_A(add_a[0]),
        .oADD_B(add_b[0]), .iADD_RESULT(add_r[0]), .oMUL_A(mul_a[0]), .oMUL_B(mul_b[0]),
        .iMUL_RESULT(mul_r[0]));

    delta_sequencer #(.N_OUT(1), .ADDR_W(2), .ADD_LAT(7), .MUL_LAT(5)) u_b (
        .iCLK(clk), .iRST_N(rst_n), .iSTART(start[1]), .oBUSY(busy[1]), .oDONE(done[1]),
        .oRD_ADDR(rd_addr[1]), .iTEACH(teach[1]), .iOUTPUT(outv[1]), .oWR_EN(wr_en[1]),
        .oWR_ADDR(wr_addr[1]), .oERROR(err[1]), .oADD_SUB(add_sub[1]), .oADD_A(add_a[1]),
        .oADD_B(add_b[1]), .iADD_RESULT(add_r[1]), .oMUL_A(mul_a[1]), .oMUL_B(mul_b[1]),
        .iMUL_RESULT(mul_r[1]));

    delta_sequencer #(.N_OUT(4), .ADDR_W(2), .ADD_LAT(3), .MUL_LAT(2)) u_c (
        .iCLK(clk), .iRST_N(rst_n), .iSTART(start[2]), .oBUSY(busy[2]), .oDONE(done[2]),
        .oRD_ADDR(rd_addr[2]), .iTEACH(teach[2]), .iOUTPUT(outv[2]), .oWR_EN(wr_en[2]),
        .oWR_ADDR(wr_addr[2]), .oERROR(err[2]), .oADD_SUB(add_sub[2]), .oADD_A(add_a[2]),
        .oADD_B(add_b[2]), .iADD_RESULT(add_r[2]), .oMUL_A(mul_a[2]), .oMUL_B(mul_b[2]),
        .iMUL_RESULT(mul_r[2]));

    // Synchronous RAM plus pipelined fp cores: result visible LAT cycles after the issue cycle.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            for (int j = 7; j > 0; j--) begin
                ap[i][j] <= ap[i][j-1];
                mp[i][j] <= mp[i][j-1];
            end
            ap[i][0] <= r2sp(add_sub[i] ? sp2r(add_a[i]) + sp2r(add_b[i])
                                        : sp2r(add_a[i]) - sp2r(add_b[i]));
            mp[i][0] <= r2sp(sp2r(mul_a[i]) * sp2r(mul_b[i]));
            teach[i] <= tmem[i][rd_addr[i]];
            outv[i]  <= omem[i][rd_addr[i]];
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            add_r[i] = ap[i][addl(i)-1];
            mul_r[i] = mp[i][mull(i)-1];
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic [31:0] ea, eb, ma, mb;
            real t, o;
            int d, k, rel;
            ea = '0; eb = '0; ma = '0; mb = '0;
            check_eq("busy", {31'b0, busy[i]}, {31'b0, (bs[i] >= 0 && cyc >= bs[i] && cyc <= be[i])});
            check_eq("done", {31'b0, done[i]}, {31'b0, (cyc == dexp[i])});
            if (done[i]) done_cnt[i]++;
            if (bs[i] >= 0 && cyc >= bs[i] && cyc <= be[i]) begin
                d   = cyc - bs[i];
                k   = d / stride(i);
                rel = d % stride(i);
                t   = sp2r(tmem[i][k]);
                o   = sp2r(omem[i][k]);
                if (rel == 1) begin ea = tmem[i][k]; eb = omem[i][k]; end
                if (rel == 2) begin ea = 32'h3f80_0000; eb = omem[i][k]; end
                if (rel == 2 + addl(i)) begin ma = omem[i][k]; mb = r2sp(1.0 - o); end
                if (rel == 2 + addl(i) + mull(i)) begin ma = r2sp(o * (1.0 - o)); mb = r2sp(t - o); end
            end
            check_eq("add_sub", {31'b0, add_sub[i]}, 32'h0);
            check_eq("add_a", add_a[i], ea);
            check_eq("add_b", add_b[i], eb);
            check_eq("mul_a", mul_a[i], ma);
            check_eq("mul_b", mul_b[i], mb);
            if (wr_en[i]) begin
                if (wq.size() == 0 || wq[0].inst != i) begin
                    check_eq("unexpected_write", 32'h1, 32'h0);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    check_eq("wr_addr", {30'b0, wr_addr[i]}, {30'b0, e.addr});
                    check_eq("wr_data", err[i], e.data);
                    check_eq("wr_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic do_start(input int i, output int s);
        @(posedge clk); #1;
        s = cyc;
        start[i] = 1'b1;
        bs[i] = s + 1;
        be[i] = s + nout(i) * stride(i);
        dexp[i] = be[i] + 1;
        done_cnt[i] = 0;
        for (int k = 0; k < nout(i); k++) begin
            wr_t e;
            e.inst = i;
            e.addr = 2'(k);
            e.data = emem[i][k];
            e.cyc  = s + stride(i) * (k + 1);
            wq.push_back(e);
        end
        @(posedge clk); #1;
        start[i] = 1'b0;
    endtask

    task automatic finish_pass(input int i);
        int n;
        n = 0;
        while (cyc <= dexp[i] + 1 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("pass_timeout", {31'b0, (n >= 400)}, 32'h0);
        check_eq("pending_writes", wq.size(), 32'h0);
        check_eq("done_count", done_cnt[i], 32'h1);
    endtask

    initial begin
        int s;
        bit seen;
        tmem[0] = '{32'h3f800000, 32'h00000000, 32'h3f800000, 32'h00000000};
        omem[0] = '{32'h3f000000, 32'h3f000000, 32'h3f800000, 32'h3e800000};
        emem[0] = '{32'h3e000000, 32'hbe000000, 32'h00000000, 32'hbd400000};
        tmem[1] = '{32'h3f800000, 32'h0, 32'h0, 32'h0};
        omem[1] = '{32'h3f000000, 32'h0, 32'h0, 32'h0};
        emem[1] = '{32'h3e000000, 32'h0, 32'h0, 32'h0};
        tmem[2] = '{32'h3f400000, 32'h3f000000, 32'h3f800000, 32'h00000000};
        omem[2] = '{32'h3e800000, 32'h3f400000, 32'h3e000000, 32'h3f000000};
        for (int k = 0; k < 4; k++) begin
            real t, o;
            t = sp2r(tmem[2][k]);
            o = sp2r(omem[2][k]);
            emem[2][k] = r2sp((t - o) * o * (1.0 - o));
        end
        for (int i = 0; i < 3; i++) begin
            start[i] = 1'b0;
            for (int j = 0; j < 8; j++) begin ap[i][j] = '0; mp[i][j] = '0; end
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_flags", {29'b0, busy[i], done[i], wr_en[i]}, 32'h0);
            check_eq("rst_addr", {28'b0, rd_addr[i], wr_addr[i]}, 32'h0);
            check_eq("rst_error", err[i], 32'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_start(1, s);
        finish_pass(1);

        do_start(0, s);
        repeat (28) @(posedge clk);
        #1; start[0] = 1'b1;
        @(posedge clk); #1; start[0] = 1'b0;
        finish_pass(0);

        do_start(0, s);
        repeat (46) @(posedge clk);
        #1;
        rst_n = 1'b0;
        be[0] = -1;
        dexp[0] = -1;
        wq.delete();
        @(negedge clk);
        check_eq("abort_flags", {29'b0, busy[0], done[0], wr_en[0]}, 32'h0);
        check_eq("abort_addr", {28'b0, rd_addr[0], wr_addr[0]}, 32'h0);
        check_eq("abort_error", err[0], 32'h0);
        check_eq("abort_ops", add_a[0] | add_b[0] | mul_a[0] | mul_b[0], 32'h0);
        repeat (3) @(posedge clk);
        #1; rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        check_eq("abort_done_count", done_cnt[0], 32'h0);
        check_eq("abort_pending", wq.size(), 32'h0);

        do_start(0, s);
        finish_pass(0);

        do_start(2, s);
        finish_pass(2);

        do_start(0, s);
        seen = 1'b0;
        for (int n = 0; n < 200 && !seen; n++) begin
            @(negedge clk);
            if (done[0]) seen = 1'b1;
        end
        check_eq("b2b_done_seen", {31'b0, seen}, 32'h1);
        do_start(0, s);
        finish_pass(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
